// File: rtl/rename_pkg.sv
// Shared configuration and types for the register-rename stage.
// Sizes are set here; rename_free_list and rename_unit_v2 both derive their widths from them.
package rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int ROB_W     = 4;

    localparam int AW       = $clog2(ARCH_REGS);
    localparam int PW       = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;

    typedef logic [AW-1:0]    areg_t;
    typedef logic [PW-1:0]    preg_t;
    typedef logic [ROB_W-1:0] rob_tag_t;

    typedef struct packed {
        preg_t    sr1_p;
        logic     s1_rdy;
        preg_t    sr2_p;
        logic     s2_rdy;
        preg_t    dr_p;
        preg_t    old_dr_p;
        rob_tag_t rob_num;
    } rename_out_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers.
// Reset preloads it with BASE..BASE+DEPTH-1; flush marks every entry free again starting at the tail.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int DEPTH = FL_DEPTH,
    parameter int BASE  = ARCH_REGS,
    parameter int DW    = PW,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pop,
    input  logic             i_push,
    input  logic [DW-1:0]    i_push_data,
    input  logic             i_flush,
    output logic [DW-1:0]    o_head_data,
    output logic [CNT_W-1:0] o_count
);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [PTR_W-1:0] w_tail_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // An overflowing push is dropped so the ring stays consistent.
    assign w_push_ok   = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop_ok    = i_pop && (r_count != '0);
    assign w_tail_next = w_push_ok ? ptr_inc(r_tail) : r_tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DW'(BASE + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= CNT_W'(DEPTH);
        end else begin
            if (w_push_ok) begin
                r_mem[r_tail] <= i_push_data;
            end
            r_tail <= w_tail_next;
            if (i_flush) begin
                r_head  <= w_tail_next;
                r_count <= CNT_W'(DEPTH);
            end else begin
                if (w_pop_ok) begin
                    r_head <= ptr_inc(r_head);
                end
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

    a_push_not_full: assert property (@(posedge clk) disable iff (rst)
        !(i_push && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/rename_unit_v2.sv
// Register-rename stage: RAT lookup, free-list allocation, busy table and ROB tagging behind valid/ready.
// Define RENAME_FLUSH_EN to add the retirement RAT and the flush/recovery ports.
module rename_unit_v2
    import rename_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [AW-1:0]    i_sr1,
    input  logic [AW-1:0]    i_sr2,
    input  logic [AW-1:0]    i_dr,
    output logic             o_stall,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [PW-1:0]    o_sr1_p,
    output logic [PW-1:0]    o_sr2_p,
    output logic             o_s1_rdy,
    output logic             o_s2_rdy,
    output logic [PW-1:0]    o_dr_p,
    output logic [PW-1:0]    o_old_dr_p,
    output logic [ROB_W-1:0] o_rob_num,
    input  logic             i_wb_valid,
    input  logic [PW-1:0]    i_wb_p,
    input  logic             i_ret_valid,
    input  logic [PW-1:0]    i_ret_old_p
`ifdef RENAME_FLUSH_EN
   ,input  logic             i_flush,
    input  logic [AW-1:0]    i_ret_arch,
    input  logic [PW-1:0]    i_ret_new_p
`endif
);

    localparam int FLC_W = $clog2(FL_DEPTH + 1);

    logic [PW-1:0]        r_rat [ARCH_REGS];
    logic [PHYS_REGS-1:0] r_busy;
    rename_out_t          r_out;
    logic                 r_out_valid;
    logic [ROB_W-1:0]     r_rob_cnt;

    logic                 w_flush;
    logic                 w_alloc;
    logic                 w_accept;
    logic [PW-1:0]        w_fl_head;
    logic [FLC_W-1:0]     w_fl_count;
    rename_out_t          w_next;

`ifdef RENAME_FLUSH_EN
    logic [PW-1:0] r_rrat [ARCH_REGS];
    logic [PW-1:0] w_rrat_next [ARCH_REGS];

    assign w_flush = i_flush;

    always_comb begin
        w_rrat_next = r_rrat;
        if (i_ret_valid && (i_ret_arch != '0)) begin
            w_rrat_next[i_ret_arch] = i_ret_new_p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rrat[i] <= PW'(i);
            end
        end else begin
            r_rrat <= w_rrat_next;
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    // Retire pushes are not forwarded: an empty list blocks allocation even while a push arrives.
    assign w_alloc     = (i_dr != '0);
    assign o_in_ready  = (!r_out_valid || i_out_ready) && (!w_alloc || (w_fl_count != '0)) && !w_flush;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_stall     = i_in_valid && !o_in_ready;

    rename_free_list #(
        .DEPTH (FL_DEPTH),
        .BASE  (ARCH_REGS),
        .DW    (PW)
    ) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .i_pop       (w_accept && w_alloc),
        .i_push      (i_ret_valid && (i_ret_old_p != '0)),
        .i_push_data (i_ret_old_p),
        .i_flush     (w_flush),
        .o_head_data (w_fl_head),
        .o_count     (w_fl_count)
    );

    // Lookups use the pre-update RAT, so a source equal to the destination sees the old mapping.
    always_comb begin
        w_next          = '0;
        w_next.sr1_p    = (i_sr1 == '0) ? '0 : r_rat[i_sr1];
        w_next.sr2_p    = (i_sr2 == '0) ? '0 : r_rat[i_sr2];
        w_next.s1_rdy   = (i_sr1 == '0) || !r_busy[w_next.sr1_p]
                          || (i_wb_valid && (i_wb_p == w_next.sr1_p));
        w_next.s2_rdy   = (i_sr2 == '0) || !r_busy[w_next.sr2_p]
                          || (i_wb_valid && (i_wb_p == w_next.sr2_p));
        w_next.dr_p     = w_alloc ? w_fl_head : '0;
        w_next.old_dr_p = w_alloc ? r_rat[i_dr] : '0;
        w_next.rob_num  = r_rob_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rat[i] <= PW'(i);
            end
`ifdef RENAME_FLUSH_EN
        end else if (w_flush) begin
            r_rat <= w_rrat_next;
`endif
        end else if (w_accept && w_alloc) begin
            r_rat[i_dr] <= w_fl_head;
        end
    end

    // A same-cycle allocation of a preg wins over a writeback clearing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (w_flush) begin
            r_busy <= '0;
        end else begin
            if (i_wb_valid && (i_wb_p != '0)) begin
                r_busy[i_wb_p] <= 1'b0;
            end
            if (w_accept && w_alloc) begin
                r_busy[w_fl_head] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_rob_cnt   <= '0;
        end else if (w_flush) begin
            r_out_valid <= 1'b0;
            r_rob_cnt   <= '0;
        end else if (w_accept) begin
            r_out       <= w_next;
            r_out_valid <= 1'b1;
            r_rob_cnt   <= r_rob_cnt + 1'b1;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_sr1_p     = r_out.sr1_p;
    assign o_sr2_p     = r_out.sr2_p;
    assign o_s1_rdy    = r_out.s1_rdy;
    assign o_s2_rdy    = r_out.s2_rdy;
    assign o_dr_p      = r_out.dr_p;
    assign o_old_dr_p  = r_out.old_dr_p;
    assign o_rob_num   = r_out.rob_num;

endmodule

// File: tb/tb_rename_unit_v2.sv
// Scoreboard bench for rename_unit_v2: a reference model predicts each renamed bundle when it is accepted.
// Define RENAME_FLUSH_EN for both RTL and bench to include the flush scenario.
module tb_rename_unit_v2;
    import rename_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [AW-1:0]    i_sr1, i_sr2, i_dr;
    logic             o_stall;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [PW-1:0]    o_sr1_p, o_sr2_p;
    logic             o_s1_rdy, o_s2_rdy;
    logic [PW-1:0]    o_dr_p, o_old_dr_p;
    logic [ROB_W-1:0] o_rob_num;
    logic             i_wb_valid;
    logic [PW-1:0]    i_wb_p;
    logic             i_ret_valid;
    logic [PW-1:0]    i_ret_old_p;
`ifdef RENAME_FLUSH_EN
    logic             i_flush;
    logic [AW-1:0]    i_ret_arch;
    logic [PW-1:0]    i_ret_new_p;
`endif

    always #5 clk = ~clk;

    rename_unit_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_sr1       (i_sr1),
        .i_sr2       (i_sr2),
        .i_dr        (i_dr),
        .o_stall     (o_stall),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_sr1_p     (o_sr1_p),
        .o_sr2_p     (o_sr2_p),
        .o_s1_rdy    (o_s1_rdy),
        .o_s2_rdy    (o_s2_rdy),
        .o_dr_p      (o_dr_p),
        .o_old_dr_p  (o_old_dr_p),
        .o_rob_num   (o_rob_num),
        .i_wb_valid  (i_wb_valid),
        .i_wb_p      (i_wb_p),
        .i_ret_valid (i_ret_valid),
        .i_ret_old_p (i_ret_old_p)
`ifdef RENAME_FLUSH_EN
       ,.i_flush     (i_flush),
        .i_ret_arch  (i_ret_arch),
        .i_ret_new_p (i_ret_new_p)
`endif
    );

    int checks   = 0;
    int failures = 0;

    rename_out_t          sbq[$];
    logic [PW-1:0]        m_rat  [ARCH_REGS];
    logic [PW-1:0]        m_rrat [ARCH_REGS];
    logic [PHYS_REGS-1:0] m_busy;
    logic [PW-1:0]        m_fl[$];
    logic [ROB_W-1:0]     m_rob;
    logic                 m_outv;
    logic                 obs_ready, obs_stall;

    function automatic rename_out_t dut_bundle();
        rename_out_t b;
        b.sr1_p    = o_sr1_p;
        b.s1_rdy   = o_s1_rdy;
        b.sr2_p    = o_sr2_p;
        b.s2_rdy   = o_s2_rdy;
        b.dr_p     = o_dr_p;
        b.old_dr_p = o_old_dr_p;
        b.rob_num  = o_rob_num;
        return b;
    endfunction

    function automatic rename_out_t mk(input int p1, input int r1, input int p2, input int r2,
                                       input int d, input int od, input int rob);
        rename_out_t b;
        b.sr1_p    = PW'(p1);
        b.s1_rdy   = r1[0];
        b.sr2_p    = PW'(p2);
        b.s2_rdy   = r2[0];
        b.dr_p     = PW'(d);
        b.old_dr_p = PW'(od);
        b.rob_num  = ROB_W'(rob);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS; i++) begin
            m_rat[i]  = PW'(i);
            m_rrat[i] = PW'(i);
        end
        m_busy = '0;
        m_fl.delete();
        for (int i = ARCH_REGS; i < PHYS_REGS; i++) m_fl.push_back(PW'(i));
        m_rob  = '0;
        m_outv = 1'b0;
        sbq.delete();
    endtask

    task automatic idle_inputs();
        i_in_valid  = 1'b0;
        i_sr1       = '0;
        i_sr2       = '0;
        i_dr        = '0;
        i_out_ready = 1'b1;
        i_wb_valid  = 1'b0;
        i_wb_p      = '0;
        i_ret_valid = 1'b0;
        i_ret_old_p = '0;
`ifdef RENAME_FLUSH_EN
        i_flush     = 1'b0;
        i_ret_arch  = '0;
        i_ret_new_p = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at the negedge, predict from the model, return at the next negedge.
    task automatic drive_cycle(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                               input logic [AW-1:0] d, input logic wbv, input logic [PW-1:0] wbp,
                               input logic rv, input logic [PW-1:0] rp, output logic accepted);
        rename_out_t e;
        logic        fl;
        logic        exp_ready;
        fl = 1'b0;
`ifdef RENAME_FLUSH_EN
        fl = i_flush;
`endif
        i_in_valid  = v;
        i_sr1       = s1;
        i_sr2       = s2;
        i_dr        = d;
        i_wb_valid  = wbv;
        i_wb_p      = wbp;
        i_ret_valid = rv;
        i_ret_old_p = rp;
        #1;
        obs_ready = o_in_ready;
        obs_stall = o_stall;
        exp_ready = (!m_outv || i_out_ready) && ((d == '0) || (m_fl.size() != 0)) && !fl;
        accepted  = v && exp_ready;
        e = '0;
        if (accepted) begin
            e.sr1_p    = (s1 == '0) ? '0 : m_rat[s1];
            e.sr2_p    = (s2 == '0) ? '0 : m_rat[s2];
            e.s1_rdy   = (s1 == '0) || !m_busy[e.sr1_p] || (wbv && (wbp == e.sr1_p));
            e.s2_rdy   = (s2 == '0) || !m_busy[e.sr2_p] || (wbv && (wbp == e.sr2_p));
            e.dr_p     = (d == '0) ? '0 : m_fl[0];
            e.old_dr_p = (d == '0) ? '0 : m_rat[d];
            e.rob_num  = m_rob;
            sbq.push_back(e);
        end
        if (wbv && (wbp != '0)) m_busy[wbp] = 1'b0;
        if (accepted && (d != '0)) begin
            m_rat[d]       = e.dr_p;
            m_busy[e.dr_p] = 1'b1;
            void'(m_fl.pop_front());
        end
        if (accepted) m_rob = m_rob + 1'b1;
        if (rv && (rp != '0)) m_fl.push_back(rp);
        m_outv = accepted ? 1'b1 : (i_out_ready ? 1'b0 : m_outv);
`ifdef RENAME_FLUSH_EN
        if (rv && (i_ret_arch != '0)) m_rrat[i_ret_arch] = i_ret_new_p;
        if (fl) begin
            m_rat  = m_rrat;
            m_busy = '0;
            m_rob  = '0;
            m_outv = 1'b0;
        end
`endif
        @(posedge clk);
        @(negedge clk);
        i_wb_valid  = 1'b0;
        i_ret_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic        acc;
        rename_out_t e;
        do_reset();
        checks++;
        if (o_out_valid !== 1'b0 || dut_bundle() !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state valid=%b got=%h want=0", o_out_valid, dut_bundle());
        end
        i_in_valid = 1'b1;
        i_dr = AW'(5);
        #1;
        checks++;
        if (o_in_ready !== 1'b1 || o_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b/%b want=1/0", o_in_ready, o_stall);
        end
        drive_cycle(1, 1, 2, 3, 0, 0, 0, 0, acc);
        e = sbq.pop_front();
        checks++;
        if (!acc || o_out_valid !== 1'b1 || dut_bundle() !== e) begin
            failures++;
            $display("[TB] FAIL reset_first_out got=%h want=%h", dut_bundle(), e);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_out_valid !== 1'b0 || dut_bundle() !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async valid=%b got=%h want=0", o_out_valid, dut_bundle());
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_basic();
        logic        acc;
        rename_out_t e;
        rename_out_t want [4];
        want[0] = mk(5, 1, 0, 1, 32, 5, 0);
        want[1] = mk(32, 0, 32, 0, 33, 6, 1);
        want[2] = mk(32, 1, 33, 0, 34, 7, 2);
        want[3] = mk(32, 1, 0, 1, 0, 0, 3);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       drive_cycle(1, 5, 0, 5, 0, 0, 0, 0, acc);
                1:       drive_cycle(1, 5, 5, 6, 0, 0, 0, 0, acc);
                2:       drive_cycle(1, 5, 6, 7, 1, 32, 0, 0, acc);
                default: drive_cycle(1, 5, 0, 0, 0, 0, 0, 0, acc);
            endcase
            e = acc ? sbq.pop_front() : '0;
            checks++;
            if (!acc || o_out_valid !== 1'b1 || dut_bundle() !== e) begin
                failures++;
                $display("[TB] FAIL basic_sb%0d got=%h want=%h", k, dut_bundle(), e);
            end
            checks++;
            if (dut_bundle() !== want[k]) begin
                failures++;
                $display("[TB] FAIL basic_const%0d got=%h want=%h", k, dut_bundle(), want[k]);
            end
        end
    endtask

    task automatic test_exhaust();
        logic        acc;
        rename_out_t e;
        do_reset();
        for (int k = 0; k < FL_DEPTH; k++) begin
            drive_cycle(1, AW'($urandom_range(0, ARCH_REGS - 1)), AW'($urandom_range(0, ARCH_REGS - 1)),
                        AW'(1 + (k % (ARCH_REGS - 1))), 0, 0, 0, 0, acc);
            e = acc ? sbq.pop_front() : '0;
            checks++;
            if (!acc || o_out_valid !== 1'b1 || dut_bundle() !== e) begin
                failures++;
                $display("[TB] FAIL exhaust_fill%0d got=%h want=%h", k, dut_bundle(), e);
            end
        end
        drive_cycle(1, 2, 3, 9, 0, 0, 1, 7, acc);
        checks++;
        if (obs_ready !== 1'b0 || obs_stall !== 1'b1 || o_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL exhaust_stall ready=%b stall=%b valid=%b want 0/1/0",
                     obs_ready, obs_stall, o_out_valid);
        end
        drive_cycle(1, 2, 3, 9, 0, 0, 0, 0, acc);
        e = acc ? sbq.pop_front() : '0;
        checks++;
        if (!acc || o_out_valid !== 1'b1 || dut_bundle() !== e || o_dr_p !== PW'(7)) begin
            failures++;
            $display("[TB] FAIL exhaust_retired got=%h want=%h dr_p want 7", dut_bundle(), e);
        end
        drive_cycle(1, 1, 1, 0, 0, 0, 0, 0, acc);
        e = acc ? sbq.pop_front() : '0;
        checks++;
        if (obs_ready !== 1'b1 || o_out_valid !== 1'b1 || dut_bundle() !== e) begin
            failures++;
            $display("[TB] FAIL exhaust_x0 ready=%b got=%h want=%h", obs_ready, dut_bundle(), e);
        end
        drive_cycle(1, 1, 1, 10, 0, 0, 0, 0, acc);
        checks++;
        if (obs_ready !== 1'b0 || obs_stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL exhaust_empty ready=%b stall=%b want 0/1", obs_ready, obs_stall);
        end
    endtask

    task automatic test_hold();
        logic        acc;
        rename_out_t e;
        rename_out_t held;
        do_reset();
        drive_cycle(1, 1, 2, 3, 0, 0, 0, 0, acc);
        held = acc ? sbq.pop_front() : '0;
        checks++;
        if (!acc || o_out_valid !== 1'b1 || dut_bundle() !== held) begin
            failures++;
            $display("[TB] FAIL hold_first got=%h want=%h", dut_bundle(), held);
        end
        i_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 4, 5, 6, 0, 0, 0, 0, acc);
            checks++;
            if (obs_ready !== 1'b0 || obs_stall !== 1'b1 || o_out_valid !== 1'b1 || dut_bundle() !== held) begin
                failures++;
                $display("[TB] FAIL hold_cycle%0d ready=%b got=%h want=%h", k, obs_ready, dut_bundle(), held);
            end
        end
        i_out_ready = 1'b1;
        drive_cycle(1, 4, 5, 6, 0, 0, 0, 0, acc);
        e = acc ? sbq.pop_front() : '0;
        checks++;
        if (!acc || dut_bundle() !== e || o_rob_num !== ROB_W'(held.rob_num + 1) || o_dr_p !== PW'(33)) begin
            failures++;
            $display("[TB] FAIL hold_release got=%h want=%h", dut_bundle(), e);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
        checks++;
        if (o_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_drain valid=%b want 0", o_out_valid);
        end
    endtask

    task automatic test_x0_wrap();
        logic        acc;
        rename_out_t e;
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            drive_cycle(1, 0, AW'(k % ARCH_REGS), 0, 0, 0, 0, 0, acc);
            e = acc ? sbq.pop_front() : '0;
            checks++;
            if (!acc || o_out_valid !== 1'b1 || dut_bundle() !== e) begin
                failures++;
                $display("[TB] FAIL x0_sb%0d got=%h want=%h", k, dut_bundle(), e);
            end
            if (k == 0 || k == 15 || k == 16) begin
                checks++;
                if (o_dr_p !== '0 || o_old_dr_p !== '0 || o_sr1_p !== '0 || o_s1_rdy !== 1'b1
                    || o_rob_num !== ROB_W'(k % 16)) begin
                    failures++;
                    $display("[TB] FAIL x0_const%0d got=%h rob want %0d", k, dut_bundle(), k % 16);
                end
            end
        end
        drive_cycle(1, 0, 0, 4, 0, 0, 0, 0, acc);
        e = acc ? sbq.pop_front() : '0;
        checks++;
        if (!acc || dut_bundle() !== e || o_dr_p !== PW'(32)) begin
            failures++;
            $display("[TB] FAIL x0_alloc got=%h want=%h dr_p want 32", dut_bundle(), e);
        end
    endtask

`ifdef RENAME_FLUSH_EN
    task automatic test_flush();
        logic        acc;
        rename_out_t e;
        do_reset();
        drive_cycle(1, 0, 0, 3, 0, 0, 0, 0, acc);
        drive_cycle(1, 0, 0, 4, 0, 0, 0, 0, acc);
        sbq.delete();
        i_ret_arch  = AW'(3);
        i_ret_new_p = PW'(32);
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 3, acc);
        i_ret_arch = '0;
        i_flush    = 1'b1;
        drive_cycle(1, 1, 1, 5, 0, 0, 0, 0, acc);
        i_flush = 1'b0;
        checks++;
        if (obs_ready !== 1'b0 || o_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_cycle ready=%b valid=%b want 0/0", obs_ready, o_out_valid);
        end
        m_fl.delete();
        for (int i = 33; i < PHYS_REGS; i++) m_fl.push_back(PW'(i));
        m_fl.push_back(PW'(3));
        drive_cycle(1, 3, 4, 5, 0, 0, 0, 0, acc);
        e = acc ? sbq.pop_front() : '0;
        checks++;
        if (!acc || dut_bundle() !== e || dut_bundle() !== mk(32, 1, 4, 1, 33, 5, 0)) begin
            failures++;
            $display("[TB] FAIL flush_after got=%h want=%h", dut_bundle(), e);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_exhaust();
        test_hold();
        test_x0_wrap();
`ifdef RENAME_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
